// File: rtl/fifo_pkg.sv
// Shared definitions for the 40-bit task fifo, its writer side and this reader.
package fifo_pkg;
  localparam int FIFO_WIDTH   = 40;
  localparam int FIFO_COUNT_W = 4;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_reader_buf.sv
// Circular register buffer of DEPTH words with occupancy and registered head word.
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter  int WIDTH = FIFO_WIDTH,
  parameter  int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [OCC_W-1:0] occ_o,
  output logic [WIDTH-1:0] head_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop;

  assign do_pop = pop_i && (occ_q != '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    // Pointers wrap modulo DEPTH, which need not be a power of two.
    if (push_i) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    if (do_pop) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    case ({push_i, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          mem_q[gi] <= '0;
        end else if (push_i && !clear_i && (wptr_q == PTR_W'(gi))) begin
          mem_q[gi] <= push_data_i;
        end
      end
    end
  endgenerate

  assign occ_o  = occ_q;
  assign head_o = mem_q[rptr_q];

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for the task fifo: issues reads with a headroom rule and
// hides the fifo's one-cycle read latency behind a small prefetch buffer.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = FIFO_WIDTH,
  parameter  int COUNT_W   = FIFO_COUNT_W,
  parameter  int BUF_DEPTH = 3,
  localparam int LVL_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  output logic               fifo_ren,
  input  logic [WIDTH-1:0]   fifo_rdata,
  input  logic [COUNT_W-1:0] fifo_count,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [LVL_W-1:0]   level
);

  logic             pend_q, pend_d;
  logic [LVL_W-1:0] occ;
  logic             pop;

  // Count the in-flight word so the buffer always has room when it lands.
  assign level     = occ + LVL_W'(pend_q);
  assign fifo_ren  = !reset && !clear && (fifo_count != '0)
                     && (level < LVL_W'(BUF_DEPTH));
  assign out_valid = (occ != '0) && !clear;
  assign pop       = out_valid && out_ready;
  assign pend_d    = fifo_ren;

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  fifo_reader_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock_i     (clock),
    .reset_i     (reset),
    .clear_i     (clear),
    .push_i      (pend_q),
    .push_data_i (fifo_rdata),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (out_data)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural task-fifo model.
module tb_fifo_reader;
  import fifo_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        fifo_rst;
  logic        fifo_ren;
  fifo_word_t  fifo_rdata;
  logic [3:0]  fifo_count;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  fifo_word_t  out_data;
  logic [1:0]  level;

  logic        wr_en;
  fifo_word_t  wr_data;

  int compared = 0;
  int failed   = 0;

  fifo_word_t fq[$];
  fifo_word_t sb[$];

  always #5 clock = ~clock;

  fifo_reader dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_count (fifo_count),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level)
  );

  // Task fifo model: pop on ren with count != 0, data visible after the edge.
  always @(posedge clock) begin : fifo_model
    int n;
    if (fifo_rst) begin
      fq.delete();
      fifo_rdata <= '0;
      fifo_count <= '0;
    end else begin
      n = fq.size();
      if (fifo_ren && n != 0) begin
        fifo_rdata <= fq.pop_front();
        n--;
      end
      if (wr_en) begin
        fq.push_back(wr_data);
        n++;
      end
      fifo_count <= 4'(n);
    end
  end

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      #1;
      n++;
    end
    chk(name, 40'(out_valid), 40'd1);
  endtask

  // Reset fifo and reader, then preload five consecutive words with the reader held in reset.
  task automatic start_fill(input fifo_word_t base);
    reset     = 1'b1;
    fifo_rst  = 1'b1;
    out_ready = 1'b0;
    step();
    fifo_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 40'(i);
      step();
    end
    wr_en = 1'b0;
    reset = 1'b0;
  endtask

  always begin
    @(negedge clock);
    #3;
    chk("ren_underflow", 40'(fifo_ren && fifo_count == 4'd0), 40'd0);
    chk("ren_headroom", 40'(fifo_ren && level == 2'd3), 40'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic       rdy;
    logic       ren;
    logic       vld;
    logic [1:0] lvl;
    fifo_word_t data;
  } vec_t;

  vec_t       vt[16];
  fifo_word_t w[3];

  initial begin
    fifo_word_t exp_w;
    int wrote, got, cyc;

    w[0] = 40'h123456789a;
    w[1] = 40'h23456789ab;
    w[2] = 40'h3456789abc;
    // Preloaded fifo, consumer always ready.
    vt[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 40'h0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 2'd1, 40'h0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 2'd2, w[0]};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 2'd2, w[1]};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 2'd1, w[2]};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 40'h0};
    // Preloaded fifo, consumer stalled then released.
    vt[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 40'h0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 2'd1, 40'h0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 2'd2, w[0]};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 2'd3, w[0]};
    vt[10] = '{1'b0, 1'b0, 1'b1, 2'd3, w[0]};
    vt[11] = '{1'b0, 1'b0, 1'b1, 2'd3, w[0]};
    vt[12] = '{1'b1, 1'b0, 1'b1, 2'd3, w[0]};
    vt[13] = '{1'b1, 1'b0, 1'b1, 2'd2, w[1]};
    vt[14] = '{1'b1, 1'b0, 1'b1, 2'd1, w[2]};
    vt[15] = '{1'b1, 1'b0, 1'b0, 2'd0, 40'h0};

    reset = 1'b1; fifo_rst = 1'b1; clear = 1'b0;
    out_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    step();
    step();
    fifo_rst = 1'b0;

    // Reader in reset for 5 cycles while the fifo fills to 3.
    for (int i = 0; i < 5; i++) begin
      wr_en   = (i < 3);
      wr_data = (i < 3) ? w[i] : '0;
      #1;
      chk($sformatf("T1 c%0d ren", i), 40'(fifo_ren), 40'd0);
      chk($sformatf("T1 c%0d valid", i), 40'(out_valid), 40'd0);
      chk($sformatf("T1 c%0d level", i), 40'(level), 40'd0);
      step();
    end
    wr_en = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        reset = 1'b1;
        out_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
          wr_en   = 1'b1;
          wr_data = w[k];
          step();
        end
        wr_en = 1'b0;
        reset = 1'b0;
      end
      out_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d ren", i), 40'(fifo_ren), 40'(vt[i].ren));
      chk($sformatf("vec%0d valid", i), 40'(out_valid), 40'(vt[i].vld));
      chk($sformatf("vec%0d level", i), 40'(level), 40'(vt[i].lvl));
      if (vt[i].vld) chk($sformatf("vec%0d data", i), out_data, vt[i].data);
      step();
    end

    // Continuous writes with a toggling consumer.
    reset = 1'b1; fifo_rst = 1'b1;
    step();
    step();
    fifo_rst = 1'b0;
    reset    = 1'b0;
    sb.delete();
    wrote = 0; got = 0; cyc = 0;
    while (got < 24 && cyc < 500) begin
      wr_en = (wrote < 24) && (fifo_count < 4'd14);
      if (wr_en) begin
        wr_data = 40'h456789abcd + 40'(wrote);
        sb.push_back(wr_data);
        wrote++;
      end
      out_ready = (cyc % 2 == 0);
      #1;
      if (out_valid && out_ready) begin
        exp_w = (sb.size() != 0) ? sb.pop_front() : 40'hdeaddeadde;
        chk($sformatf("T4 word%0d", got), out_data, exp_w);
        got++;
      end
      step();
      cyc++;
    end
    wr_en = 1'b0;
    chk("T4 received", 40'(got), 40'd24);
    chk("T4 leftover", 40'(sb.size()), 40'd0);

    // Clear with occ=2 and one word in flight.
    start_fill(40'ha000000000);
    step(); step(); step();
    #1;
    chk("T5 level before clear", 40'(level), 40'd3);
    clear = 1'b1;
    #1;
    chk("T5 ren in clear", 40'(fifo_ren), 40'd0);
    chk("T5 valid in clear", 40'(out_valid), 40'd0);
    step();
    clear = 1'b0;
    #1;
    chk("T5 level after clear", 40'(level), 40'd0);
    out_ready = 1'b1;
    wait_valid("T5 valid timeout");
    chk("T5 first after clear", out_data, 40'ha000000003);
    step();
    #1;
    chk("T5 second valid", 40'(out_valid), 40'd1);
    chk("T5 second after clear", out_data, 40'ha000000004);
    step();

    // Reset mid-operation.
    start_fill(40'hb000000000);
    step(); step(); step();
    #1;
    chk("T6 level before reset", 40'(level), 40'd3);
    reset = 1'b1; fifo_rst = 1'b1;
    sb.delete();
    step();
    #1;
    chk("T6 ren", 40'(fifo_ren), 40'd0);
    chk("T6 valid", 40'(out_valid), 40'd0);
    chk("T6 level", 40'(level), 40'd0);
    fifo_rst = 1'b0;
    wr_en = 1'b1;
    wr_data = 40'hc0ffee1234;
    step();
    wr_en = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    wait_valid("T6 valid timeout");
    chk("T6 word after reset", out_data, 40'hc0ffee1234);
    step();
    #1;
    chk("T6 drained", 40'(out_valid), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
